// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to a variable-latency
// instruction memory and presents fetched words through a one-entry skid buffer.
module fetch_unit #(
   parameter int unsigned PC_W     = 9,
   parameter int unsigned INS_W    = 32,
   parameter int unsigned RESET_PC = 0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [INS_W-1:0] imem_rdata,
   input  logic             redirect_valid,
   input  logic [PC_W-1:0]  redirect_pc,
   input  logic             stall,
   output logic             inst_valid,
   output logic [INS_W-1:0] instruction,
   output logic [PC_W-1:0]  inst_pc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               req_q, req_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    tgt_q, tgt_d;
   logic               out_valid_d;
   logic [INS_W-1:0]   out_word_d;
   logic [PC_W-1:0]    out_pc_d;
   logic               skid_valid_q, skid_valid_d;
   logic [INS_W-1:0]   skid_word_q, skid_word_d;
   logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

   logic               ack;
   logic               consume;
   logic               out_free;

   assign imem_req  = req_q;
   assign imem_addr = pc_q;

   assign ack      = imem_ack & req_q;
   assign consume  = inst_valid & ~stall;
   assign out_free = ~inst_valid | consume;

   // State register and all datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         pc_q         <= PC_W'(RESET_PC);
         tgt_q        <= '0;
         inst_valid   <= 1'b0;
         instruction  <= '0;
         inst_pc      <= '0;
         skid_valid_q <= 1'b0;
         skid_word_q  <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         pc_q         <= pc_d;
         tgt_q        <= tgt_d;
         inst_valid   <= out_valid_d;
         instruction  <= out_word_d;
         inst_pc      <= out_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_word_q  <= skid_word_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   // Next-state, PC sequencing and output/skid slot management
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      out_valid_d  = inst_valid;
      out_word_d   = instruction;
      out_pc_d     = inst_pc;
      skid_valid_d = skid_valid_q;
      skid_word_d  = skid_word_q;
      skid_pc_d    = skid_pc_q;

      if (redirect_valid) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               pc_d    = redirect_pc;
               state_d = BUSY;
            end
            BUSY: begin
               if (ack) begin
                  pc_d = redirect_pc;
               end else begin
                  tgt_d   = redirect_pc;
                  state_d = FLUSH;
               end
            end
            FLUSH: begin
               if (ack) begin
                  pc_d    = redirect_pc;
                  state_d = BUSY;
               end else begin
                  tgt_d = redirect_pc;
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         if (consume) begin
            out_valid_d = 1'b0;
         end
         // Skid contents always win the output slot over fresh memory data
         if (skid_valid_q && out_free) begin
            out_valid_d  = 1'b1;
            out_word_d   = skid_word_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (!skid_valid_q) begin
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (ack) begin
                  pc_d = pc_q + PC_W'(4);
                  if (out_free && !skid_valid_q) begin
                     out_valid_d = 1'b1;
                     out_word_d  = imem_rdata;
                     out_pc_d    = pc_q;
                  end else begin
                     skid_valid_d = 1'b1;
                     skid_word_d  = imem_rdata;
                     skid_pc_d    = pc_q;
                     state_d      = IDLE;
                  end
               end
            end
            FLUSH: begin
               if (ack) begin
                  pc_d    = tgt_q;
                  state_d = BUSY;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      req_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming/stall/latency/flush,
// plus hand-written sequences for skid redirect, PC wrap and reset mid-flush.
module tb_fetch_unit;

   localparam int unsigned PC_W  = 9;
   localparam int unsigned INS_W = 32;

   logic             clk;
   logic             reset;
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic             imem_ack;
   logic [INS_W-1:0] imem_rdata;
   logic             redirect_valid;
   logic [PC_W-1:0]  redirect_pc;
   logic             stall;
   logic             inst_valid;
   logic [INS_W-1:0] instruction;
   logic [PC_W-1:0]  inst_pc;

   int unsigned n_applied;
   int unsigned n_fail;
   int unsigned lat_wait;
   logic [7:0]  wcnt;

   fetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC(0)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .inst_valid     (inst_valid),
      .instruction    (instruction),
      .inst_pc        (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [INS_W-1:0] mem_word(input logic [PC_W-1:0] a);
      return {16'hC0DE, 7'h00, a};
   endfunction

   // Memory model: acks after lat_wait wait cycles of a held request
   assign imem_ack   = imem_req && (wcnt == 8'(lat_wait));
   assign imem_rdata = imem_ack ? mem_word(imem_addr) : '0;

   always_ff @(posedge clk) begin
      if (reset || !imem_req || imem_ack) wcnt <= '0;
      else                                wcnt <= wcnt + 8'd1;
   end

   typedef struct {
      int unsigned     lat;
      logic            rst;
      logic            rv;
      logic [PC_W-1:0] rpc;
      logic            st;
      logic            e_req;
      logic [PC_W-1:0] e_addr;
      logic            e_valid;
      logic [PC_W-1:0] e_pc;
   } vec_t;

   vec_t tbl [27];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_applied++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Drive one cycle of inputs, advance past the edge, then check the outputs
   task automatic step(input string nm, input logic r, input logic rv,
                       input logic [PC_W-1:0] rpc, input logic st,
                       input logic e_req, input logic [PC_W-1:0] e_addr,
                       input logic e_valid, input logic [PC_W-1:0] e_pc);
      reset          = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      stall          = st;
      @(posedge clk);
      @(negedge clk);
      chk({nm, ".req"},   32'(imem_req),   32'(e_req));
      chk({nm, ".addr"},  32'(imem_addr),  32'(e_addr));
      chk({nm, ".valid"}, 32'(inst_valid), 32'(e_valid));
      if (e_valid) begin
         chk({nm, ".pc"},   32'(inst_pc),  32'(e_pc));
         chk({nm, ".inst"}, instruction,   mem_word(e_pc));
      end
   endtask

   initial begin
      n_applied      = 0;
      n_fail         = 0;
      lat_wait       = 0;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      stall          = 1'b0;

      //           lat rst rv  rpc      st   req addr     vld pc
      // streaming, 0-wait, with a 4-cycle stall filling the skid
      tbl[0]  = '{0, 1'b1, 1'b0, 9'd0,  1'b0, 1'b0, 9'd0,  1'b0, 9'd0};
      tbl[1]  = '{0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd0,  1'b0, 9'd0};
      tbl[2]  = '{0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd4,  1'b1, 9'd0};
      tbl[3]  = '{0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd8,  1'b1, 9'd4};
      tbl[4]  = '{0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd12, 1'b1, 9'd8};
      tbl[5]  = '{0, 1'b0, 1'b0, 9'd0,  1'b1, 1'b0, 9'd16, 1'b1, 9'd8};
      tbl[6]  = '{0, 1'b0, 1'b0, 9'd0,  1'b1, 1'b0, 9'd16, 1'b1, 9'd8};
      tbl[7]  = '{0, 1'b0, 1'b0, 9'd0,  1'b1, 1'b0, 9'd16, 1'b1, 9'd8};
      tbl[8]  = '{0, 1'b0, 1'b0, 9'd0,  1'b1, 1'b0, 9'd16, 1'b1, 9'd8};
      tbl[9]  = '{0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0, 9'd16, 1'b1, 9'd12};
      tbl[10] = '{0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd16, 1'b0, 9'd0};
      tbl[11] = '{0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd20, 1'b1, 9'd16};
      tbl[12] = '{0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd24, 1'b1, 9'd20};
      // 3-cycle memory, then redirect to 0x40 while 0x08 is outstanding
      tbl[13] = '{2, 1'b1, 1'b0, 9'd0,  1'b0, 1'b0, 9'd0,  1'b0, 9'd0};
      tbl[14] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd0,  1'b0, 9'd0};
      tbl[15] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd0,  1'b0, 9'd0};
      tbl[16] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd0,  1'b0, 9'd0};
      tbl[17] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd4,  1'b1, 9'd0};
      tbl[18] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd4,  1'b0, 9'd0};
      tbl[19] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd4,  1'b0, 9'd0};
      tbl[20] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd8,  1'b1, 9'd4};
      tbl[21] = '{2, 1'b0, 1'b1, 9'h40, 1'b0, 1'b1, 9'd8,  1'b0, 9'd0};
      tbl[22] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'd8,  1'b0, 9'd0};
      tbl[23] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'h40, 1'b0, 9'd0};
      tbl[24] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'h40, 1'b0, 9'd0};
      tbl[25] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'h40, 1'b0, 9'd0};
      tbl[26] = '{2, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 9'h44, 1'b1, 9'h40};

      @(negedge clk);
      for (int i = 0; i < 27; i++) begin
         lat_wait = tbl[i].lat;
         step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].st,
              tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc);
      end

      // Redirect while both output and skid are full under stall
      lat_wait = 0;
      step("skid.rst",   1'b1, 1'b0, 9'd0,    1'b0, 1'b0, 9'd0,    1'b0, 9'd0);
      step("skid.go",    1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'd0,    1'b0, 9'd0);
      step("skid.f0",    1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'd4,    1'b1, 9'd0);
      step("skid.fill",  1'b0, 1'b0, 9'd0,    1'b1, 1'b0, 9'd8,    1'b1, 9'd0);
      step("skid.redir", 1'b0, 1'b1, 9'h100,  1'b1, 1'b1, 9'h100,  1'b0, 9'd0);
      step("skid.first", 1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'h104,  1'b1, 9'h100);

      // Start from a redirect near the top of the address space; then a redirect
      // coinciding with an ack in BUSY
      step("wrap.rst",   1'b1, 1'b0, 9'd0,    1'b0, 1'b0, 9'd0,    1'b0, 9'd0);
      step("wrap.redir", 1'b0, 1'b1, 9'd504,  1'b0, 1'b1, 9'd504,  1'b0, 9'd0);
      step("wrap.504",   1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'd508,  1'b1, 9'd504);
      step("wrap.508",   1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'd0,    1'b1, 9'd508);
      step("wrap.0",     1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'd4,    1'b1, 9'd0);
      step("ackred",     1'b0, 1'b1, 9'h10,   1'b0, 1'b1, 9'h10,   1'b0, 9'd0);
      step("ackred.1st", 1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'h14,   1'b1, 9'h10);

      // Re-target inside FLUSH, then reset while a FLUSH is pending
      lat_wait = 2;
      step("fl.rst",     1'b1, 1'b0, 9'd0,    1'b0, 1'b0, 9'd0,    1'b0, 9'd0);
      step("fl.go",      1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'd0,    1'b0, 9'd0);
      step("fl.r80",     1'b0, 1'b1, 9'h80,   1'b0, 1'b1, 9'd0,    1'b0, 9'd0);
      step("fl.rC0",     1'b0, 1'b1, 9'hC0,   1'b0, 1'b1, 9'd0,    1'b0, 9'd0);
      step("fl.ack",     1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'hC0,   1'b0, 9'd0);
      step("fl.w1",      1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'hC0,   1'b0, 9'd0);
      step("fl.w2",      1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'hC0,   1'b0, 9'd0);
      step("fl.C0",      1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'hC4,   1'b1, 9'hC0);
      step("fl.r20",     1'b0, 1'b1, 9'h20,   1'b0, 1'b1, 9'hC4,   1'b0, 9'd0);
      step("fl.midrst",  1'b1, 1'b0, 9'd0,    1'b0, 1'b0, 9'd0,    1'b0, 9'd0);
      chk("fl.midrst.inst",   instruction,  32'd0);
      chk("fl.midrst.instpc", 32'(inst_pc), 32'd0);
      step("fl.restart", 1'b0, 1'b0, 9'd0,    1'b0, 1'b1, 9'd0,    1'b0, 9'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
      $finish;
   end

endmodule
